// File: rtl/btn_debounce_ch.sv
// Single pushbutton channel: 2-flop synchroniser, symmetric counter debounce,
// registered press/release pulses, toggle latch and one-shot long-press pulse.
module btn_debounce_ch #(
  parameter int unsigned DEBOUNCE_CYCLES = 10,
  parameter int unsigned LONG_CYCLES     = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic b,
  output logic level,
  output logic press_p,
  output logic release_p,
  output logic toggle,
  output logic long_p
);

  localparam int unsigned CntW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(LONG_CYCLES + 1);

  localparam logic [CntW-1:0]  CntLast   = CntW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HoldW-1:0] HoldMax   = HoldW'(LONG_CYCLES);
  localparam logic [HoldW-1:0] HoldFire  = HoldW'(LONG_CYCLES - 1);

  logic             s1_q, s2_q;
  logic             level_q, level_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             toggle_q, toggle_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             long_q, long_d;

  always_comb begin
    level_d   = level_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    toggle_d  = toggle_q;
    hold_d    = hold_q;
    long_d    = 1'b0;

    // Any sample agreeing with the accepted level restarts the count.
    if (s2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      level_d   = s2_q;
      cnt_d     = '0;
      press_d   = s2_q;
      release_d = ~s2_q;
      if (s2_q) begin
        toggle_d = ~toggle_q;
      end
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (!level_q) begin
      hold_d = '0;
    end else if (hold_q != HoldMax) begin
      hold_d = hold_q + 1'b1;
      // Saturation at HoldMax guarantees a single fire per press.
      long_d = (hold_q == HoldFire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      level_q   <= 1'b0;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      toggle_q  <= 1'b0;
      hold_q    <= '0;
      long_q    <= 1'b0;
    end else begin
      s1_q      <= b;
      s2_q      <= s1_q;
      level_q   <= level_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      toggle_q  <= toggle_d;
      hold_q    <= hold_d;
      long_q    <= long_d;
    end
  end

  assign level     = level_q;
  assign press_p   = press_q;
  assign release_p = release_q;
  assign toggle    = toggle_q;
  assign long_p    = long_q;

endmodule

// File: rtl/btn_debounce_multi.sv
// N-channel pushbutton conditioner: optional polarity inversion followed by
// one independent btn_debounce_ch per button.
module btn_debounce_multi #(
  parameter int unsigned N_CH            = 5,
  parameter int unsigned DEBOUNCE_CYCLES = 10,
  parameter int unsigned LONG_CYCLES     = 1000,
  parameter int unsigned ACTIVE_LOW      = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press_p,
  output logic [N_CH-1:0] release_p,
  output logic [N_CH-1:0] toggle,
  output logic [N_CH-1:0] long_p
);

  logic [N_CH-1:0] b;

  // Normalise to active-high before the synchronisers.
  assign b = (ACTIVE_LOW != 0) ? ~btn : btn;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .b        (b[i]),
      .level    (level[i]),
      .press_p  (press_p[i]),
      .release_p(release_p[i]),
      .toggle   (toggle[i]),
      .long_p   (long_p[i])
    );
  end

endmodule

// File: tb/tb_btn_debounce_multi.sv
// Directed self-checking bench for btn_debounce_multi (4 channels, debounce 4,
// long press 20). Tick t is the t-th rising edge after an input change.
module tb_btn_debounce_multi;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'h0;
  logic [3:0] level, press_p, release_p, toggle, long_p;

  int checks   = 0;
  int failures = 0;

  btn_debounce_multi #(
    .N_CH           (4),
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .ACTIVE_LOW     (0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .level    (level),
    .press_p  (press_p),
    .release_p(release_p),
    .toggle   (toggle),
    .long_p   (long_p)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 4'hF;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if ({level, press_p, release_p, toggle, long_p} !== 20'h0) begin
        $display("FAIL reset_outputs: got %h want 00000",
                 {level, press_p, release_p, toggle, long_p});
        failures++;
      end
    end
    rst = 1'b0;
    for (int t = 1; t <= 6; t++) begin
      tick();
      checks++;
      if (t == 6) begin
        if (press_p !== 4'hF || level !== 4'hF) begin
          $display("FAIL reset_repress: press_p=%b level=%b want 1111/1111", press_p, level);
          failures++;
        end
      end else if (press_p !== 4'h0 || level !== 4'h0) begin
        $display("FAIL reset_early: t=%0d press_p=%b level=%b want 0000/0000",
                 t, press_p, level);
        failures++;
      end
    end
    checks++;
    if (toggle !== 4'hF) begin
      $display("FAIL reset_toggle: got %b want 1111", toggle);
      failures++;
    end
    btn = 4'h0;
  endtask

  task automatic test_release_all();
    int rt = 0;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (release_p !== 4'h0) begin
        checks++;
        if (t != 6 || release_p !== 4'hF) begin
          $display("FAIL release_all_pulse: t=%0d release_p=%b want t=6 1111", t, release_p);
          failures++;
        end
        rt = t;
      end
    end
    checks++;
    if (rt != 6 || level !== 4'h0 || toggle !== 4'hF) begin
      $display("FAIL release_all: rt=%0d level=%b toggle=%b want 6/0000/1111",
               rt, level, toggle);
      failures++;
    end
  endtask

  task automatic test_clean_press();
    int np = 0, pt = 0, nl = 0, lt = 0, nr = 0, rt = 0;
    btn[0] = 1'b1;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (press_p[0]) begin np++; pt = t; end
      if (long_p[0])  begin nl++; lt = t; end
    end
    checks++;
    if (np != 1 || pt != 6) begin
      $display("FAIL clean_press: count=%0d at=%0d want 1 at 6", np, pt);
      failures++;
    end
    checks++;
    if (nl != 1 || lt != 26) begin
      $display("FAIL clean_long: count=%0d at=%0d want 1 at 26", nl, lt);
      failures++;
    end
    btn[0] = 1'b0;
    for (int t = 1; t <= 10; t++) begin
      tick();
      if (release_p[0]) begin nr++; rt = t; end
      if (long_p[0])    nl++;
    end
    checks++;
    if (nr != 1 || rt != 6 || level[0] !== 1'b0 || nl != 1) begin
      $display("FAIL clean_release: count=%0d at=%0d level=%b longs=%0d want 1/6/0/1",
               nr, rt, level[0], nl);
      failures++;
    end
  endtask

  task automatic test_bounce();
    logic pat [9] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    int np = 0, pt = 0, nr = 0;
    btn[1] = pat[0];
    for (int t = 1; t <= 16; t++) begin
      tick();
      if (press_p[1])   begin np++; pt = t; end
      if (release_p[1]) nr++;
      btn[1] = (t < 9) ? pat[t] : 1'b1;
    end
    checks++;
    if (np != 1 || pt != 11 || nr != 0) begin
      $display("FAIL bounce_press: count=%0d at=%0d releases=%0d want 1/11/0", np, pt, nr);
      failures++;
    end
    checks++;
    if (level[1] !== 1'b1 || toggle[1] !== 1'b0) begin
      $display("FAIL bounce_state: level=%b toggle=%b want 1/0", level[1], toggle[1]);
      failures++;
    end
    btn[1] = 1'b0;
    for (int t = 0; t < 8; t++) tick();
    checks++;
    if (level[1] !== 1'b0) begin
      $display("FAIL bounce_release: level=%b want 0", level[1]);
      failures++;
    end
  endtask

  task automatic test_toggle();
    int np = 0, nr = 0, nl = 0;
    logic exp_tog;
    rst = 1'b1;
    btn = 4'h0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (toggle !== 4'h0) begin
      $display("FAIL toggle_start: got %b want 0000", toggle);
      failures++;
    end
    exp_tog = 1'b1;
    for (int k = 0; k < 2; k++) begin
      btn[2] = 1'b1;
      for (int t = 1; t <= 10; t++) begin
        tick();
        if (press_p[2]) np++;
        if (long_p[2])  nl++;
        if (t == 6) begin
          checks++;
          if (toggle[2] !== exp_tog) begin
            $display("FAIL toggle_flip: press %0d toggle=%b want %b", k, toggle[2], exp_tog);
            failures++;
          end
        end
      end
      btn[2] = 1'b0;
      for (int t = 1; t <= 10; t++) begin
        tick();
        if (release_p[2]) nr++;
        if (long_p[2])    nl++;
      end
      exp_tog = ~exp_tog;
    end
    checks++;
    if (np != 2 || nr != 2 || nl != 0 || toggle[2] !== 1'b0) begin
      $display("FAIL toggle_counts: press=%0d release=%0d long=%0d toggle=%b want 2/2/0/0",
               np, nr, nl, toggle[2]);
      failures++;
    end
  endtask

  task automatic test_short();
    btn[3] = 1'b1;
    for (int t = 1; t <= 15; t++) begin
      tick();
      if (t == 3) btn[3] = 1'b0;
      checks++;
      if ({level, press_p, release_p, toggle, long_p} !== 20'h0) begin
        $display("FAIL short_glitch: t=%0d outputs=%h want 00000",
                 t, {level, press_p, release_p, toggle, long_p});
        failures++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int nl = 0, lt = 0;
    btn = 4'b0101;
    for (int t = 1; t <= 8; t++) begin
      tick();
      if (t == 6) begin
        checks++;
        if (press_p !== 4'b0101 || toggle !== 4'b0101) begin
          $display("FAIL simul_press: press_p=%b toggle=%b want 0101/0101", press_p, toggle);
          failures++;
        end
      end
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({level, press_p, release_p, toggle, long_p} !== 20'h0) begin
      $display("FAIL midpress_reset: outputs=%h want 00000",
               {level, press_p, release_p, toggle, long_p});
      failures++;
    end
    tick();
    rst = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      tick();
      if (t == 6) begin
        checks++;
        if (press_p !== 4'b0101 || level !== 4'b0101 || toggle !== 4'b0101) begin
          $display("FAIL re_press: press_p=%b level=%b toggle=%b want 0101 each",
                   press_p, level, toggle);
          failures++;
        end
      end
      if (long_p !== 4'h0) begin
        nl++;
        if (lt == 0) lt = t;
        checks++;
        if (long_p !== 4'b0101) begin
          $display("FAIL re_long_mask: long_p=%b want 0101", long_p);
          failures++;
        end
      end
    end
    checks++;
    if (nl != 1 || lt != 26) begin
      $display("FAIL re_long: count=%0d at=%0d want 1 at 26", nl, lt);
      failures++;
    end
    btn = 4'h0;
  endtask

  initial begin
    test_reset();
    test_release_all();
    test_clean_press();
    test_bounce();
    test_toggle();
    test_short();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_debounce_multi.md
Name: btn_debounce_multi

Overview:
- Parametrised N-channel pushbutton conditioner. Successor to the single-button debounce/toggle LED logic.
- Per channel it provides:
  - 2-flop synchroniser
  - counter-based debounce, symmetric for press and release
  - one-cycle press and release pulses
  - a toggle latch
  - a one-shot long-press pulse
- Sits between board button pins and user logic (LED drivers, mode selectors) in every FPGA top level.

Parameters:
- N_CH, 5, number of button channels (≥1).
- DEBOUNCE_CYCLES, 10, consecutive clocks of disagreement needed to accept a new level (≥1).
- LONG_CYCLES, 1000, clocks a debounced press must be held before long_p fires (> DEBOUNCE_CYCLES).
- ACTIVE_LOW, 0, 1 = raw buttons are active-low; inverted before the synchroniser.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- btn  in  N_CH  raw asynchronous button inputs
- level  out  N_CH  debounced button state, 1 = pressed
- press_p  out  N_CH  one-cycle pulse on each accepted 0→1 of level
- release_p  out  N_CH  one-cycle pulse on each accepted 1→0 of level
- toggle  out  N_CH  flips on every press_p
- long_p  out  N_CH  one-cycle pulse when a press has been held LONG_CYCLES clocks

Behaviour:
- Reset (rst high at a clk edge):
  - all outputs 0
  - synchroniser flops, debounce counters and hold counters 0
  - reset has priority over all other activity
  - mid-press reset discards all progress
- Button held through reset: after rst falls it is treated as a fresh press (full latency, then press_p).
- Channels are fully independent. No shared state except clk/rst.
- Input conditioning: b = btn ^ {N_CH{ACTIVE_LOW}}, passed through 2 flops (s1 then s2). Synchroniser flops carry no reset-dependent logic other than clearing.
- Debounce, per channel, on each clk edge:
  - If s2 == level: cnt ← 0.
  - Else if cnt == DEBOUNCE_CYCLES-1: level ← s2, cnt ← 0.
  - Else: cnt ← cnt+1.
  - Any glitch back to the level value before the count completes restarts the count from 0.
- Latency: b stable from edge k gives the new level, with the matching pulse, visible after edge k+DEBOUNCE_CYCLES+1. Press and release latency are identical.
- Pulses:
  - press_p and release_p are registered, high exactly in the cycle level first shows the new value.
  - They are never both high on one channel.
- Toggle: toggle ← ~toggle in the same edge that asserts press_p. Release does not affect it.
- Long press:
  - hold counter clears while level == 0 and counts while level == 1.
  - It saturates at LONG_CYCLES.
  - long_p is high for exactly one cycle, when hold reaches LONG_CYCLES-1 → LONG_CYCLES, i.e. the LONG_CYCLES-th cycle after press_p.
  - At most one long_p per press.
  - Releasing before that point produces no long_p.
- Widths:
  - cnt width = $clog2(DEBOUNCE_CYCLES+1).
  - hold width = $clog2(LONG_CYCLES+1).
  - No counter ever wraps.
- Simultaneous events across channels are all reported in the same cycle.

Decomposition:
- No shared package needed. Counter widths are derived locally with $clog2.
- One natural sub-module: btn_debounce_ch, a single-channel synchroniser + debounce + pulse + toggle + long-press.
- btn_debounce_multi is a generate loop of N_CH instances plus the ACTIVE_LOW inversion.

Test Plan (N_CH=4, DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=0):
- Reset with btn=4'b1111 held 3 cycles, then release rst → all outputs 0 during reset. Every channel shows press_p=1 and level=1 exactly 5 edges after the first post-reset edge. toggle becomes 4'b1111.
- btn[0] clean press held 30 cycles → press_p[0] one cycle at latency 5. long_p[0] one cycle exactly 20 cycles after press_p[0], none afterwards. Release → release_p[0] at latency 5, level[0]=0.
- btn[1] bounce pattern 1,0,1,1,0,1,1,1,1,… → no press_p during the bounce. press_p[1] only 5 edges after the start of the final 4+ stable-high run.
- btn[2] pressed 10 cycles, released, pressed again → toggle[2] goes 0→1→0. No long_p[2]. Two press_p and two release_p pulses.
- btn[3] high for exactly 3 cycles (shorter than DEBOUNCE_CYCLES) → no change on any output.
- btn[0] and btn[2] press in the same cycle; assert rst 2 cycles after press_p while held → both press_p in the same cycle. Reset clears level, toggle and hold. After reset, both re-press with latency 5, and long_p is measured from the new press_p.
